// File: rtl/branch_pkg.sv
// Shared constants for the branch predictor: address-mode encodings and
// helpers that build the direction-counter init/threshold values for any width.
package branch_pkg;

  localparam logic ADDR_MODE_PC = 1'b0;
  localparam logic ADDR_MODE_RD = 1'b1;

  // MSB set, all lower bits clear; also the taken threshold.
  function automatic logic [31:0] ctr_weak_taken(input int bits);
    return 32'(1) << (bits - 1);
  endfunction

  // MSB clear, all lower bits set.
  function automatic logic [31:0] ctr_weak_not_taken(input int bits);
    return (32'(1) << (bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down counter next-state logic; inc wins if both are asserted.
module sat_counter #(
  parameter int Width = 2
) (
  input  logic [Width-1:0] count,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] count_next
);

  always_comb begin
    count_next = count;
    if (inc) begin
      if (count != {Width{1'b1}}) count_next = count + Width'(1);
    end else if (dec) begin
      if (count != {Width{1'b0}}) count_next = count - Width'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, resolve-time training and a registered misprediction redirect.
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int Entries  = 16,
  parameter int CtrBits  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_target,
  input  logic                res_valid,
  input  logic [WordSize-1:0] res_pc,
  input  logic                res_addr_mode,
  input  logic [WordSize-1:0] res_imm,
  input  logic [WordSize-1:0] res_rs1d,
  input  logic                res_taken,
  input  logic                res_pred_taken,
  input  logic [WordSize-1:0] res_pred_target,
  input  logic                bp_clear,
  output logic                redirect_valid,
  output logic [WordSize-1:0] redirect_pc,
  output logic [15:0]         mispredict_count
);

  localparam int IdxBits = $clog2(Entries);
  localparam int TagBits = WordSize - IdxBits - 2;
  localparam logic [CtrBits-1:0] CtrInit   = CtrBits'(ctr_weak_not_taken(CtrBits));
  localparam logic [CtrBits-1:0] CtrThresh = CtrBits'(ctr_weak_taken(CtrBits));

  logic                valid_arr  [Entries];
  logic [TagBits-1:0]  tag_arr    [Entries];
  logic [WordSize-1:0] target_arr [Entries];
  logic [CtrBits-1:0]  ctr_arr    [Entries];

  logic [IdxBits-1:0]  fetch_idx, res_idx;
  logic [TagBits-1:0]  fetch_tag, res_tag;
  logic [WordSize-1:0] rd_sum, res_target, res_next_pc;
  logic                res_hit, mispredict;

  logic                redirect_valid_reg;
  logic [WordSize-1:0] redirect_pc_reg;
  logic [15:0]         mispredict_count_reg;

  assign fetch_idx = fetch_pc[IdxBits+1:2];
  assign fetch_tag = fetch_pc[WordSize-1:IdxBits+2];
  assign res_idx   = res_pc[IdxBits+1:2];
  assign res_tag   = res_pc[WordSize-1:IdxBits+2];

  assign pred_hit    = valid_arr[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
  assign pred_taken  = pred_hit && (ctr_arr[fetch_idx] >= CtrThresh);
  assign pred_target = pred_hit ? target_arr[fetch_idx] : fetch_pc + WordSize'(4);

  // Register-relative targets must be halfword aligned, so bit 0 is dropped.
  assign rd_sum      = res_imm + res_rs1d;
  assign res_target  = (res_addr_mode == ADDR_MODE_RD) ? {rd_sum[WordSize-1:1], 1'b0}
                                                       : res_pc + res_imm;
  assign res_next_pc = res_taken ? res_target : res_pc + WordSize'(4);
  assign res_hit     = valid_arr[res_idx] && (tag_arr[res_idx] == res_tag);
  assign mispredict  = res_valid &&
                       ((res_pred_taken != res_taken) ||
                        (res_taken && res_pred_taken && (res_pred_target != res_target)));

  genvar gi;
  generate
    for (gi = 0; gi < Entries; gi++) begin : gen_entry
      logic                valid_reg;
      logic [TagBits-1:0]  tag_reg;
      logic [WordSize-1:0] target_reg;
      logic [CtrBits-1:0]  ctr_reg;
      logic [CtrBits-1:0]  ctr_next;
      logic                sel;

      assign sel = res_valid && (res_idx == IdxBits'(gi));

      sat_counter #(.Width(CtrBits)) u_ctr (
        .count      (ctr_reg),
        .inc        (res_taken),
        .dec        (!res_taken),
        .count_next (ctr_next)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= CtrInit;
        end else if (bp_clear) begin
          valid_reg <= 1'b0;
        end else if (sel && res_hit) begin
          ctr_reg <= ctr_next;
          if (res_taken) target_reg <= res_target;
        end else if (sel && res_taken) begin
          valid_reg  <= 1'b1;
          tag_reg    <= res_tag;
          target_reg <= res_target;
          ctr_reg    <= CtrThresh;
        end
      end

      assign valid_arr[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign ctr_arr[gi]    = ctr_reg;
    end
  endgenerate

  // Redirect and statistics keep working while the table is being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_reg   <= 1'b0;
      redirect_pc_reg      <= '0;
      mispredict_count_reg <= '0;
    end else begin
      redirect_valid_reg <= mispredict;
      if (mispredict) begin
        redirect_pc_reg <= res_next_pc;
        if (mispredict_count_reg != 16'hFFFF)
          mispredict_count_reg <= mispredict_count_reg + 16'd1;
      end
    end
  end

  assign redirect_valid   = redirect_valid_reg;
  assign redirect_pc      = redirect_pc_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: hand-computed lookups, redirects
// and counter values checked with immediate assertions.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_addr_mode;
  logic [31:0] res_imm, res_rs1d;
  logic        res_taken, res_pred_taken;
  logic [31:0] res_pred_target;
  logic        bp_clear;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.WordSize(32), .Entries(16), .CtrBits(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_addr_mode    (res_addr_mode),
    .res_imm          (res_imm),
    .res_rs1d         (res_rs1d),
    .res_taken        (res_taken),
    .res_pred_taken   (res_pred_taken),
    .res_pred_target  (res_pred_target),
    .bp_clear         (bp_clear),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input logic [31:0] pc, input logic mode, input logic [31:0] imm,
                         input logic [31:0] rs1d, input logic taken, input logic ptaken,
                         input logic [31:0] ptarget);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_addr_mode   = mode;
    res_imm         = imm;
    res_rs1d        = rs1d;
    res_taken       = taken;
    res_pred_taken  = ptaken;
    res_pred_target = ptarget;
    $display("resolve pc=%h mode=%0d imm=%h rs1d=%h taken=%0d pred_taken=%0d pred_target=%h clear=%0d",
             pc, mode, imm, rs1d, taken, ptaken, ptarget, bp_clear);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    bp_clear  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic hit, input logic taken,
                        input logic [31:0] tgt);
    fetch_pc = pc;
    #1;
    check("pred_hit", 32'(pred_hit), 32'(hit));
    check("pred_taken", 32'(pred_taken), 32'(taken));
    check("pred_target", pred_target, tgt);
    $display("lookup pc=%h hit=%0d taken=%0d target=%h", pc, pred_hit, pred_taken, pred_target);
  endtask

  task automatic check_redirect(input logic rv, input logic [31:0] rpc, input logic [15:0] cnt);
    check("redirect_valid", 32'(redirect_valid), 32'(rv));
    check("redirect_pc", redirect_pc, rpc);
    check("mispredict_count", 32'(mispredict_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h0; res_valid = 1'b0; res_pc = 32'h0; res_addr_mode = 1'b0;
    res_imm = 32'h0; res_rs1d = 32'h0; res_taken = 1'b0; res_pred_taken = 1'b0;
    res_pred_target = 32'h0; bp_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_redirect(1'b0, 32'h0, 16'd0);
    rst = 1'b0;
    lookup(32'h100, 1'b0, 1'b0, 32'h104);

    // Allocate 0x100 -> 0x140; invisible until after the edge.
    set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
    lookup(32'h100, 1'b0, 1'b0, 32'h104);
    step();
    check_redirect(1'b1, 32'h140, 16'd1);
    lookup(32'h100, 1'b1, 1'b1, 32'h140);
    @(posedge clk); #1;
    check_redirect(1'b0, 32'h140, 16'd1);

    // Four not-taken: 10 -> 01 -> 00 -> 00 -> 00, redirect only on the first.
    set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h140);
    step();
    check_redirect(1'b1, 32'h104, 16'd2);
    for (int i = 0; i < 3; i++) begin
      set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      check_redirect(1'b0, 32'h104, 16'd2);
    end
    lookup(32'h100, 1'b1, 1'b0, 32'h140);

    // Four taken: 00 -> 01 -> 10 -> 11 -> 11, correctly predicted.
    for (int i = 0; i < 4; i++) begin
      set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h140);
      step();
      check_redirect(1'b0, 32'h104, 16'd2);
      if (i == 0) lookup(32'h100, 1'b1, 1'b0, 32'h140);
    end
    lookup(32'h100, 1'b1, 1'b1, 32'h140);
    // 11 -> 10 keeps predicting taken.
    set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h140);
    step();
    check_redirect(1'b1, 32'h104, 16'd3);
    lookup(32'h100, 1'b1, 1'b1, 32'h140);

    // RD mode: 0x5 + 0x200 = 0x205 -> 0x204; wrong predicted target.
    set_res(32'h308, 1'b1, 32'h5, 32'h200, 1'b1, 1'b1, 32'h200);
    step();
    check_redirect(1'b1, 32'h204, 16'd4);
    lookup(32'h308, 1'b1, 1'b1, 32'h204);
    set_res(32'h308, 1'b1, 32'h5, 32'h200, 1'b1, 1'b1, 32'h204);
    step();
    check_redirect(1'b0, 32'h204, 16'd4);

    // Not-taken miss does not allocate.
    set_res(32'h410, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check_redirect(1'b0, 32'h204, 16'd4);
    lookup(32'h410, 1'b0, 1'b0, 32'h414);

    // Fall-through wraps past the top of the address space.
    set_res(32'hFFFF_FFFC, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0);
    step();
    check_redirect(1'b1, 32'h0, 16'd5);
    lookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Clear wins over a taken allocation; redirect still fires.
    bp_clear = 1'b1;
    set_res(32'h200, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    check_redirect(1'b1, 32'h210, 16'd6);
    lookup(32'h100, 1'b0, 1'b0, 32'h104);
    lookup(32'h308, 1'b0, 1'b0, 32'h30C);
    lookup(32'h200, 1'b0, 1'b0, 32'h204);

    // 0x100 and 0x140 share index 0; second allocation evicts the first.
    set_res(32'h100, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h140);
    step();
    check_redirect(1'b0, 32'h210, 16'd6);
    lookup(32'h100, 1'b1, 1'b1, 32'h140);
    set_res(32'h140, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h160);
    step();
    check_redirect(1'b0, 32'h210, 16'd6);
    lookup(32'h140, 1'b1, 1'b1, 32'h160);
    lookup(32'h100, 1'b0, 1'b0, 32'h104);

    // Asynchronous reset while a redirect is showing and a resolve is pending.
    set_res(32'h140, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h160);
    step();
    check_redirect(1'b1, 32'h144, 16'd7);
    set_res(32'h140, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_redirect(1'b0, 32'h0, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_valid = 1'b0;
    check_redirect(1'b0, 32'h0, 16'd0);
    lookup(32'h140, 1'b0, 1'b0, 32'h144);
    @(posedge clk); #1;
    check_redirect(1'b0, 32'h0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
